// File: rtl/hwrandom_pipe.sv
// Entropy pipeline: XOR-reduced ring-oscillator samples, optional von Neumann
// debiasing, word assembly, repetition-count health test and a FWFT output FIFO.
module hwrandom_pipe #(
  parameter int NUM_RINGOSCS = 131,
  parameter int WORD_BITS    = 8,
  parameter int SAMPLE_DIV   = 64,
  parameter int FIFO_DEPTH   = 16,
  parameter int RCT_LIMIT    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_RINGOSCS-1:0]       ring_bits,
  input  logic                          mode,
  output logic [WORD_BITS-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          health_fail,
  output logic [31:0]                   disp_word
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int RW = $clog2(RCT_LIMIT + 1);
  localparam int BW = $clog2(WORD_BITS + 1);

  logic [NUM_RINGOSCS-1:0] sync1, sync2;
  logic [DW-1:0]           div_cnt;
  logic                    strobe, raw_bit;
  logic [RW-1:0]           run_cnt;
  logic                    last_bit;
  logic                    mode_q;
  logic                    pair_full, pair_first;
  logic                    acc_valid, acc_bit;
  logic [WORD_BITS-1:0]    word, word_next, push_word;
  logic [WORD_BITS:0]      word_wide;
  logic [BW-1:0]           bit_cnt;
  logic                    push_pend;
  logic [WORD_BITS-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    pop, full, wr_ok;
  logic [15:0]             drop_cnt, last_pushed, push_low;

  assign strobe    = (div_cnt == DW'(SAMPLE_DIV - 1));
  assign raw_bit   = ^sync2;
  assign word_wide = {word, acc_bit};
  assign word_next = word_wide[WORD_BITS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      div_cnt <= '0;
    end else begin
      sync1   <= ring_bits;
      sync2   <= sync1;
      div_cnt <= strobe ? '0 : div_cnt + DW'(1);
    end
  end

  // Run length saturates at the limit; the sticky flag follows one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt     <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (strobe) begin
        last_bit <= raw_bit;
        if (run_cnt == '0 || raw_bit != last_bit)
          run_cnt <= RW'(1);
        else if (run_cnt != RW'(RCT_LIMIT))
          run_cnt <= run_cnt + RW'(1);
      end
      if (run_cnt == RW'(RCT_LIMIT))
        health_fail <= 1'b1;
    end
  end

  always_comb begin
    acc_valid = 1'b0;
    acc_bit   = raw_bit;
    if (strobe && !health_fail) begin
      if (!mode) begin
        acc_valid = 1'b1;
      end else if (pair_full && raw_bit != pair_first) begin
        acc_valid = 1'b1;
        acc_bit   = pair_first;
      end
    end
  end

  // A mode change or a health failure discards any half-built pair and word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q     <= 1'b0;
      pair_full  <= 1'b0;
      pair_first <= 1'b0;
      word       <= '0;
      bit_cnt    <= '0;
      push_pend  <= 1'b0;
      push_word  <= '0;
    end else begin
      mode_q    <= mode;
      push_pend <= 1'b0;
      if (health_fail || mode != mode_q) begin
        pair_full <= 1'b0;
        word      <= '0;
        bit_cnt   <= '0;
      end else begin
        if (strobe && mode) begin
          pair_full <= !pair_full;
          if (!pair_full) pair_first <= raw_bit;
        end
        if (acc_valid) begin
          word <= word_next;
          if (bit_cnt == BW'(WORD_BITS - 1)) begin
            bit_cnt   <= '0;
            push_pend <= 1'b1;
            push_word <= word_next;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
      end
    end
  end

  generate
    if (WORD_BITS >= 16) begin : g_low_wide
      assign push_low = push_word[15:0];
    end else begin : g_low_narrow
      assign push_low = {{(16 - WORD_BITS){1'b0}}, push_word};
    end
  endgenerate

  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = (count != '0) && out_ready;
  assign wr_ok = push_pend && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      drop_cnt    <= '0;
      last_pushed <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + PW'(1);
        last_pushed <= push_low;
      end else if (push_pend && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_data   = mem[rd_ptr];
  assign out_valid  = (count != '0);
  assign fifo_count = count;
  assign disp_word  = {drop_cnt, last_pushed};

endmodule

// File: tb/tb_hwrandom_pipe.sv
// Directed bench for hwrandom_pipe: table of single-word cases plus hand-written
// sequences for debiasing, FIFO full/drain, simultaneous push/pop and health test.
module tb_hwrandom_pipe;

  localparam int NRO = 131;
  localparam int DIV = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NRO-1:0] ring_bits = '0;
  logic           mode = 1'b0;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [4:0]     fifo_count;
  logic           health_fail;
  logic [31:0]    disp_word;

  int n_checks = 0;
  int n_bad    = 0;

  hwrandom_pipe #(
    .NUM_RINGOSCS(NRO), .WORD_BITS(8), .SAMPLE_DIV(DIV), .FIFO_DEPTH(16), .RCT_LIMIT(32)
  ) dut (
    .clk(clk), .reset(reset), .ring_bits(ring_bits), .mode(mode),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .health_fail(health_fail), .disp_word(disp_word)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        mode;
    logic [15:0] raw;
    int          nraw;
    logic [7:0]  exp_word;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random ring pattern whose XOR parity equals b.
  task automatic set_ring(input logic b);
    logic [159:0] r;
    logic [NRO-1:0] v;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    v = r[NRO-1:0];
    if ((^v) != b) v[0] = ~v[0];
    ring_bits = v;
  endtask

  // Called just after a strobe edge; returns just after the next strobe edge.
  task automatic send_bit(input logic b);
    set_ring(b);
    tick(DIV);
  endtask

  task automatic send_bit_tog(input logic b);
    set_ring(b);
    mode = ~mode;
    tick(1);
    mode = ~mode;
    tick(DIV - 1);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 7; k >= 0; k--) send_bit(w[k]);
  endtask

  task automatic send_pairs(input logic [7:0] w, input int nbits);
    for (int k = nbits - 1; k >= 0; k--) begin
      send_bit(w[k]);
      send_bit(~w[k]);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    tick(3);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] wv(input int i);
    return 8'(i * 29 + 8'h35);
  endfunction

  initial begin
    vecs[0] = '{mode: 1'b0, raw: 16'h00B2, nraw: 8,  exp_word: 8'hB2};
    vecs[1] = '{mode: 1'b0, raw: 16'h005A, nraw: 8,  exp_word: 8'h5A};
    vecs[2] = '{mode: 1'b0, raw: 16'h00F0, nraw: 8,  exp_word: 8'hF0};
    vecs[3] = '{mode: 1'b1, raw: 16'h69A5, nraw: 16, exp_word: 8'h6C};

    // Reset held while the rings toggle.
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_ring(i[0]);
      tick(1);
    end
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_data", {24'b0, out_data}, 32'd0);
    check("rst_count", {27'b0, fifo_count}, 32'd0);
    check("rst_health", {31'b0, health_fail}, 32'd0);
    check("rst_disp", disp_word, 32'd0);

    // Single-word vectors; exact strobe alignment is implied by the bit timing.
    for (int v = 0; v < 4; v++) begin
      mode = vecs[v].mode;
      do_reset();
      for (int k = vecs[v].nraw - 1; k >= 0; k--) send_bit(vecs[v].raw[k]);
      check("vec_valid_pre", {31'b0, out_valid}, 32'd0);
      tick(1);
      check("vec_valid", {31'b0, out_valid}, 32'd1);
      check("vec_data", {24'b0, out_data}, {24'b0, vecs[v].exp_word});
      check("vec_count", {27'b0, fifo_count}, 32'd1);
      check("vec_disp", disp_word, {24'b0, vecs[v].exp_word});
    end

    // Von Neumann: pairs 10,11,01,00,10 leave 101, then 11001 completes 0xB9.
    mode = 1'b1;
    do_reset();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    send_bit(1); send_bit(0); send_bit(0); send_bit(1); send_bit(0);
    send_pairs(8'h19, 5);
    tick(1);
    check("vn_count1", {27'b0, fifo_count}, 32'd1);
    check("vn_word1", {24'b0, out_data}, 32'hB9);
    // Leave a partial bit and a half pair, then toggle mode: 0xC5 must come out clean.
    send_bit(1); send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    send_bit_tog(1); send_bit(0);
    send_pairs(8'h45, 7);
    tick(1);
    check("vn_count2", {27'b0, fifo_count}, 32'd2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("vn_word2", {24'b0, out_data}, 32'hC5);
    check("vn_count3", {27'b0, fifo_count}, 32'd1);

    // Overfill: 18 words into 16 slots.
    mode = 1'b0;
    do_reset();
    for (int i = 0; i < 18; i++) send_word(wv(i));
    tick(1);
    check("full_count", {27'b0, fifo_count}, 32'd16);
    check("full_drops", {16'b0, disp_word[31:16]}, 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", {31'b0, out_valid}, 32'd1);
      check("drain_data", {24'b0, out_data}, {24'b0, wv(i)});
      tick(1);
    end
    check("drain_empty", {31'b0, out_valid}, 32'd0);
    check("drain_count", {27'b0, fifo_count}, 32'd0);
    out_ready = 1'b0;

    // Push into a full FIFO in the same cycle as a pop.
    do_reset();
    for (int i = 0; i < 16; i++) send_word(wv(i));
    send_word(8'h3C);
    check("pp_full", {27'b0, fifo_count}, 32'd16);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("pp_count", {27'b0, fifo_count}, 32'd16);
    check("pp_disp", disp_word, 32'h0000_003C);
    out_ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("pp_data", {24'b0, out_data}, {24'b0, wv(i)});
      tick(1);
    end
    check("pp_last", {24'b0, out_data}, 32'h3C);
    tick(1);
    check("pp_empty", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Stuck source: 0x5A then 32 identical ones (four 0xFF words) trips the test.
    do_reset();
    send_word(8'h5A);
    set_ring(1'b1);
    tick(31 * DIV);
    check("hf_31", {31'b0, health_fail}, 32'd0);
    tick(DIV);
    check("hf_32", {31'b0, health_fail}, 32'd0);
    tick(1);
    check("hf_set", {31'b0, health_fail}, 32'd1);
    check("hf_count", {27'b0, fifo_count}, 32'd5);
    send_word(8'h96);
    send_word(8'h69);
    tick(1);
    check("hf_blocked", {27'b0, fifo_count}, 32'd5);
    check("hf_sticky", {31'b0, health_fail}, 32'd1);
    out_ready = 1'b1;
    check("hf_d0", {24'b0, out_data}, 32'h5A);
    tick(1);
    check("hf_d1", {24'b0, out_data}, 32'hFF);
    tick(1);
    out_ready = 1'b0;
    check("hf_left", {27'b0, fifo_count}, 32'd3);
    // Asynchronous reset between edges clears everything at once.
    #3;
    reset = 1'b1;
    #1;
    check("ar_count", {27'b0, fifo_count}, 32'd0);
    check("ar_health", {31'b0, health_fail}, 32'd0);
    check("ar_disp", disp_word, 32'd0);
    check("ar_valid", {31'b0, out_valid}, 32'd0);
    tick(2);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/hwrandom_pipe.md
Name: hwrandom_pipe

Overview:
Parametrised entropy pipeline replacing the fixed-width core datapath: samples an array of free-running ring-oscillator outputs, XOR-reduces them, optionally applies von Neumann debiasing and assembles the bits into WORD_BITS-wide words. Words are buffered in a FIFO and presented on a valid/ready stream to the UART transmitter.
A repetition-count health test blocks output from a stuck source. A 32-bit debug word is exported for the 7-segment display.

Parameters:
NUM_RINGOSCS, 131, number of ring-oscillator inputs XOR-reduced per sample
WORD_BITS, 8, output word width (1..32)
SAMPLE_DIV, 64, clk cycles between samples (>=2)
FIFO_DEPTH, 16, words of buffering (power of two, >=2)
RCT_LIMIT, 32, consecutive identical raw bits that trip the health test (>=2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ring_bits  in  NUM_RINGOSCS  raw asynchronous ring-oscillator outputs
mode  in  1  0 = raw XOR bits, 1 = von Neumann debiased
out_data  out  WORD_BITS  head-of-FIFO word
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer accepts the word
fifo_count  out  clog2(FIFO_DEPTH)+1  words currently held
health_fail  out  1  sticky repetition-count failure
disp_word  out  32  debug word for the display

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. All registers clear on reset; every output reads 0. This includes out_valid, fifo_count, health_fail and disp_word.
- Synchronisation: ring_bits passes through a 2-flop synchroniser (reset to 0).
- Sample strobe: a counter runs 0..SAMPLE_DIV-1 and strobes when it wraps. On the strobe, raw_bit is the XOR of all synchronised bits.
- Health test:
  - The run counter counts consecutive equal raw_bits and restarts at 1 on a change.
  - When the counter reaches RCT_LIMIT, health_fail sets one cycle later and stays set until reset.
  - While health_fail is set, no bits are accepted and the partial word is discarded.
  - FIFO contents already stored remain readable.
- Mode 0: every raw_bit is accepted.
- Mode 1 (von Neumann):
  - raw bits are paired.
  - On the second bit of a pair: if it differs from the first, the first bit is accepted; if equal, nothing is accepted.
  - Any change of mode clears the pair state and the partial word in the cycle after the change.
- Assembler:
  - Each accepted bit shifts in: word = {word[WORD_BITS-2:0], bit}.
  - A bit counter counts accepted bits. When it reaches WORD_BITS, the word is pushed to the FIFO on the following clock and the counter returns to 0.
- FIFO:
  - First-word fall-through. out_valid = (count != 0); out_data is the head word.
  - A pop occurs on out_valid && out_ready.
  - A push while full is accepted only if a pop occurs in the same cycle; otherwise the word is dropped and drop_cnt increments.
  - drop_cnt saturates at 16'hFFFF.
  - Simultaneous push and pop leaves count unchanged. out_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- disp_word: {drop_cnt[15:0], last_pushed[15:0]}.
  - last_pushed is the most recently pushed word, zero-extended, or its low 16 bits if WORD_BITS > 16.
  - It updates on the cycle the push completes.
- Reset asserted mid-word or mid-transfer: the partial word, FIFO contents, counters and health state are all lost immediately.

Test Plan:
1. Reset held, ring_bits toggling -> all outputs 0. Release -> first sample strobe occurs SAMPLE_DIV cycles after the counter starts.
2. mode=0, WORD_BITS=8, raw_bit sequence forced 1,0,1,1,0,0,1,0 (via chosen ring_bits patterns) -> one push of 8'hB2. disp_word=32'h0000_00B2; out_valid rises the cycle after the push.
3. mode=1, raw pairs 10,11,01,00,10 -> accepted bits 1,0,1 only; the partial word is 3'b101. Toggling mode afterwards clears it, so 8 further accepted bits yield a word with no stale bits.
4. out_ready=0, FIFO_DEPTH=16, generate 18 words -> fifo_count=16, disp_word[31:16]=2. Then out_ready=1 -> 16 words drain in order, out_valid drops after the last.
5. Full FIFO, push and pop in the same cycle -> count stays 16, no drop recorded, and the new word appears last in drain order.
6. ring_bits held constant -> health_fail sets after RCT_LIMIT=32 identical samples and no further pushes occur. Existing words still drain. health_fail clears only on reset.
